uart_rx_reg_cntrl: RTL and testbench
====================================

Name: uart_rx_reg_cntrl

Overview:
Receive-side register controller for the UART. It captures bytes from the UART receiver on its one-cycle Rx_done strobe into an internal synchronous FIFO. It serves host reads requested on an asynchronous level signal Rd_req, which it synchronises and rising-edge detects. It mirrors the transmit-side controller: registered one-cycle status pulses for overflow and underflow, and Empty/Full flags toward the host.

Parameters:
DATA_W, 8, width of a received character
DEPTH, 16, FIFO entries; power of 2, minimum 2
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (asserted at 0)
Rx_done  input  1  one-cycle strobe from UART receiver, clk domain; Rx_data valid in same cycle
Rx_data  input  DATA_W  received character
Rx_ferr  input  1  framing error flag for the Rx_data qualified by Rx_done
Rd_req  input  1  host read request, asynchronous level; each rising edge requests one character
Out_data  output  DATA_W  character popped by last successful read; holds until next pop
Out_vld  output  1  one-cycle pulse, Out_data updated
Overflow  output  1  one-cycle pulse, character dropped because FIFO full
Underflow  output  1  one-cycle pulse, read requested while FIFO empty
Frame_err  output  1  one-cycle pulse, character discarded for framing error (see Optional Feature)
Empty  output  1  registered, occupancy == 0
Full  output  1  registered, occupancy == DEPTH
Count  output  CNT_W  registered occupancy

Behaviour:
- Reset (rst=0, asynchronous): pointers, Count=0, Empty=1, Full=0, Out_data=0, Out_vld=0, Overflow=0, Underflow=0, Frame_err=0, sync stages=0.
- Rd_req path: 2-FF synchroniser (sync1, sync2) plus prev register. rd_edge = sync2 & ~prev. Rd_req held high is one request; a new request needs Rd_req low for at least 2 clk cycles.
- Read latency: Rd_req first sampled high at edge E1, so rd_edge is true between E2 and E3. At E3: if !Empty, pop, Out_data = head, Out_vld=1 for one cycle. If Empty, Underflow=1 for one cycle; Out_data unchanged.
- Write: at the edge where Rx_done=1: if !Full, push Rx_data. Empty/Full/Count reflect it after that same edge. If Full and no pop at that edge, drop the character and pulse Overflow for one cycle.
- Simultaneous push and pop at one edge: both succeed, Count unchanged, including when Full. Push while Empty with a pop in the same edge is impossible, because the pop is gated by the registered Empty, so Underflow fires and the push proceeds.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count is the sole full/empty source; Count never exceeds DEPTH and never goes below 0.
- Status pulses are registered and never wider than 1 cycle. Overflow and Underflow can coincide.
- Reset mid-operation discards FIFO contents and any in-flight request. A Rd_req held high through reset deassertion produces a request edge after sync (prev resets to 0).

Optional Feature:
Macro UART_RX_FERR_DROP_EN.
- Defined: a character with Rx_done=1 and Rx_ferr=1 is not pushed and Frame_err pulses 1 cycle. Overflow is not raised for such a character even if Full.
- Undefined: Rx_ferr is ignored, all characters are handled per the normal write rules, and Frame_err is tied 0.

Decomposition:
- Package uart_pkg: UART_DATA_W=8 default, RX_FIFO_DEPTH=16, and a status-bit index enum {ST_OVF, ST_UNF, ST_FERR} for later register mapping.
- Sub-module uart_sync_fifo: storage, pointers, Count/Empty/Full, push/pop interface. The parent holds the synchroniser, edge detect, and pulse logic.

Test Plan:
- Reset, push 0xA5 via Rx_done -> Empty=0, Count=1. Rd_req rises -> Out_vld 3 edges later with Out_data=0xA5, then Empty=1.
- Push 16 characters 0x00..0x0F, then a 17th 0xFF -> Full=1, Overflow pulse on the 17th. Read 16 times -> 0x00..0x0F in order, 0xFF never appears.
- Rd_req toggled with FIFO empty -> Underflow 1-cycle pulse, Out_vld=0, Out_data unchanged.
- FIFO Full (16 entries), Rx_done=0x55 on the same edge as a pop -> no Overflow, Count stays 16. Drain -> last character 0x55.
- Rd_req held high 20 cycles -> exactly one pop. Rd_req low 1 cycle then high -> no second request guaranteed; low 2 cycles -> second pop.
- UART_RX_FERR_DROP_EN defined: Rx_done with Rx_ferr=1, data 0x3C -> Frame_err pulse, Count unchanged. Undefined: 0x3C stored, Frame_err stays 0.
- rst=0 asserted with Count=5 -> all outputs return to reset values immediately, without waiting for a clock.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART register controllers.
//   UART_DATA_W   : default character width
//   RX_FIFO_DEPTH : default receive FIFO depth
//   status_bit_e  : bit positions of the status pulses in the status register
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int RX_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_OVF,
    ST_UNF,
    ST_FERR
  } status_bit_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
// Single-clock FIFO: storage, wrapping pointers and an occupancy counter that
// is the only source of the empty/full flags.
// The caller must never pop while empty, and never push while full unless a
// pop happens on the same edge.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   push, wr_data  : write strobe and data
//   pop            : read strobe, rd_data is the current head (combinational)
//   empty, full    : registered flags
//   count          : registered occupancy
// -----------------------------------------------------------------------------
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = RX_FIFO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_nxt;

  // Storage is not reset; entries are only ever read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/uart_rx_reg_cntrl.sv
// -----------------------------------------------------------------------------
// uart_rx_reg_cntrl
// Receive-side register controller. Characters from the UART receiver are
// pushed into a FIFO on Rx_done; the host pops one character per rising edge
// of the asynchronous Rd_req level.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   Rx_done, Rx_data  : receiver strobe and character
//   Rx_ferr           : framing error for the character qualified by Rx_done
//   Rd_req            : asynchronous host read request level
//   Out_data, Out_vld : last popped character and its one-cycle valid pulse
//   Overflow          : pulse, character dropped because FIFO was full
//   Underflow         : pulse, read requested while FIFO was empty
//   Frame_err         : pulse, character discarded for a framing error
//   Empty, Full, Count: registered FIFO status
// Build option:
//   UART_RX_FERR_DROP_EN : when defined, characters flagged with Rx_ferr are
//                          discarded and reported on Frame_err; otherwise
//                          Rx_ferr is ignored and Frame_err is tied low.
// -----------------------------------------------------------------------------
module uart_rx_reg_cntrl
  import uart_pkg::*;
#(
  parameter  int DATA_W = UART_DATA_W,
  parameter  int DEPTH  = RX_FIFO_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Rx_done,
  input  logic [DATA_W-1:0] Rx_data,
  input  logic              Rx_ferr,
  input  logic              Rd_req,
  output logic [DATA_W-1:0] Out_data,
  output logic              Out_vld,
  output logic              Overflow,
  output logic              Underflow,
  output logic              Frame_err,
  output logic              Empty,
  output logic              Full,
  output logic [CNT_W-1:0]  Count
);

  logic              sync1;
  logic              sync2;
  logic              prev;
  logic              rd_edge;
  logic              pop;
  logic              push;
  logic              wr_ok;
  logic              ferr_drop;
  logic [DATA_W-1:0] head;

  // Two-flop synchroniser for Rd_req plus a delayed copy for edge detection.
  // prev resets to 0 so a request held through reset still produces an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= Rd_req;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rd_edge = sync2 & ~prev;

`ifdef UART_RX_FERR_DROP_EN
  assign ferr_drop = Rx_done & Rx_ferr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Frame_err <= 1'b0;
    end else begin
      Frame_err <= ferr_drop;
    end
  end
`else
  logic unused_ferr;

  assign unused_ferr = Rx_ferr;
  assign ferr_drop   = 1'b0;
  assign Frame_err   = 1'b0;
`endif

  // Pop is gated by the registered Empty, so a push into an empty FIFO can
  // never pair with a pop. A pop on the same edge frees room for a push
  // even when Full.
  assign pop   = rd_edge & ~Empty;
  assign wr_ok = Rx_done & ~ferr_drop;
  assign push  = wr_ok & (~Full | pop);

  uart_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (Rx_data),
    .pop     (pop),
    .rd_data (head),
    .empty   (Empty),
    .full    (Full),
    .count   (Count)
  );

  // Registered one-cycle status pulses and the held read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Out_data  <= '0;
      Out_vld   <= 1'b0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Out_vld   <= pop;
      Overflow  <= wr_ok & Full & ~pop;
      Underflow <= rd_edge & Empty;
      if (pop) begin
        Out_data <= head;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_reg_cntrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_reg_cntrl
// Self-checking bench for uart_rx_reg_cntrl: a directed vector table, directed
// multi-cycle sequences and a randomized run, all compared against a
// queue-based model of the receive FIFO and read-request timing.
// -----------------------------------------------------------------------------
module tb_uart_rx_reg_cntrl;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       Rx_done = 1'b0;
  logic [7:0] Rx_data = '0;
  logic       Rx_ferr = 1'b0;
  logic       Rd_req = 1'b0;
  logic [7:0] Out_data;
  logic       Out_vld;
  logic       Overflow;
  logic       Underflow;
  logic       Frame_err;
  logic       Empty;
  logic       Full;
  logic [4:0] Count;

  int nChecks = 0;
  int nFail   = 0;

  // Model state: FIFO contents, cycle numbers of pending pops, last popped byte.
  logic [7:0] q[$];
  int         popAt[$];
  int         cyc = 0;
  bit         prevRd = 1'b0;
  logic [7:0] lastData = '0;
  bit         expVld, expOvf, expUnf, expFerr;

  typedef struct {
    bit         rx;
    logic [7:0] data;
    bit         ferr;
    bit         rd;
    int         count;
    bit         empty;
    bit         full;
    bit         vld;
    logic [7:0] outData;
    bit         ovf;
    bit         unf;
    bit         fe;
  } vec_t;

  vec_t vecs[13];

  uart_rx_reg_cntrl #(
    .DATA_W (8),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Rx_done   (Rx_done),
    .Rx_data   (Rx_data),
    .Rx_ferr   (Rx_ferr),
    .Rd_req    (Rd_req),
    .Out_data  (Out_data),
    .Out_vld   (Out_vld),
    .Overflow  (Overflow),
    .Underflow (Underflow),
    .Frame_err (Frame_err),
    .Empty     (Empty),
    .Full      (Full),
    .Count     (Count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int count, input bit empty, input bit full,
                             input bit vld, input logic [7:0] data, input bit ovf,
                             input bit unf, input bit fe);
    chk({tag, " Count"},     32'(Count),     32'(count));
    chk({tag, " Empty"},     32'(Empty),     32'(empty));
    chk({tag, " Full"},      32'(Full),      32'(full));
    chk({tag, " Out_vld"},   32'(Out_vld),   32'(vld));
    chk({tag, " Out_data"},  32'(Out_data),  32'(data));
    chk({tag, " Overflow"},  32'(Overflow),  32'(ovf));
    chk({tag, " Underflow"}, 32'(Underflow), 32'(unf));
    chk({tag, " Frame_err"}, 32'(Frame_err), 32'(fe));
  endtask

  // Drive inputs just after a falling edge, let one rising edge pass, return
  // on the next falling edge where outputs are stable.
  task automatic applyStimulus(input bit rx, input logic [7:0] data, input bit ferr, input bit rd);
    Rx_done = rx;
    Rx_data = data;
    Rx_ferr = ferr;
    Rd_req  = rd;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference behaviour for one rising edge. A read request first seen high
  // at edge n is served at edge n+2 using the FIFO state before that edge.
  task automatic modelStep(input bit rx, input logic [7:0] data, input bit ferr, input bit rd);
    bit readNow;
    bit dropF;
    bit rxEff;
    bit popOk;
    bit pushOk;
    int sz;
    readNow = 1'b0;
    if (rd && !prevRd) popAt.push_back(cyc + 2);
    prevRd = rd;
    if (popAt.size() > 0 && popAt[0] == cyc) begin
      readNow = 1'b1;
      void'(popAt.pop_front());
    end
    sz = q.size();
`ifdef UART_RX_FERR_DROP_EN
    dropF = rx && ferr;
`else
    dropF = 1'b0;
`endif
    rxEff   = rx && !dropF;
    popOk   = readNow && (sz > 0);
    pushOk  = rxEff && ((sz < DEPTH) || popOk);
    expVld  = popOk;
    expUnf  = readNow && (sz == 0);
    expOvf  = rxEff && !pushOk;
    expFerr = dropF;
    if (popOk) lastData = q.pop_front();
    if (pushOk) q.push_back(data);
    cyc++;
  endtask

  task automatic cycle(input string tag, input bit rx, input logic [7:0] data,
                       input bit ferr, input bit rd);
    modelStep(rx, data, ferr, rd);
    applyStimulus(rx, data, ferr, rd);
    checkOutput(tag, q.size(), q.size() == 0, q.size() == DEPTH,
                expVld, lastData, expOvf, expUnf, expFerr);
  endtask

  task automatic modelReset();
    q.delete();
    popAt.delete();
    cyc      = 0;
    prevRd   = 1'b0;
    lastData = '0;
  endtask

  task automatic resetDut(input bit rdLevel);
    Rx_done = 1'b0;
    Rx_data = '0;
    Rx_ferr = 1'b0;
    Rd_req  = rdLevel;
    rst     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    modelReset();
  endtask

  task automatic readOne(input string tag);
    cycle(tag, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) cycle(tag, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bit rdLvl;
    int lowRun;

    // rx, data, ferr, rd | count, empty, full, vld, outData, ovf, unf, fe
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
`ifdef UART_RX_FERR_DROP_EN
    vecs[10] = '{1'b1, 8'h3C, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
`else
    vecs[10] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
`endif

    // Reset state, then the directed vector table.
    resetDut(1'b0);
    checkOutput("reset", 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].rx, vecs[i].data, vecs[i].ferr, vecs[i].rd);
      checkOutput($sformatf("vec%0d", i), vecs[i].count, vecs[i].empty, vecs[i].full,
                  vecs[i].vld, vecs[i].outData, vecs[i].ovf, vecs[i].unf, vecs[i].fe);
    end

    // Fill to 16, overflow on the 17th, drain in order.
    resetDut(1'b0);
    for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("ovf17", 1'b1, 8'hFF, 1'b0, 1'b0);
    cycle("ovfIdle", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) readOne("drain");
    chk("drainLastByte", 32'(Out_data), 32'h0F);

    // Full FIFO with a push landing on the same edge as a pop.
    resetDut(1'b0);
    for (int i = 0; i < 16; i++) cycle("refill", 1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cycle("fullRd", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("fullRd", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("fullPushPop", 1'b1, 8'h55, 1'b0, 1'b0);
    cycle("fullIdle", 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) readOne("drain55");
    chk("drainLast55", 32'(Out_data), 32'h55);

    // Held request is one pop; two low cycles re-arm.
    resetDut(1'b0);
    for (int i = 0; i < 3; i++) cycle("hold", 1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    repeat (20) cycle("holdHigh", 1'b0, 8'h00, 1'b0, 1'b1);
    chk("heldOnePop", 32'(Count), 32'd2);
    repeat (2) cycle("holdLow", 1'b0, 8'h00, 1'b0, 1'b0);
    readOne("rearm");
    chk("rearmSecondPop", 32'(Count), 32'd1);

    // Randomized traffic: filling bias first, then draining bias.
    resetDut(1'b0);
    rdLvl  = 1'b0;
    lowRun = 2;
    for (int i = 0; i < 800; i++) begin
      bit rx;
      rx = ($urandom_range(0, 99) < ((i < 400) ? 70 : 15));
      if (rdLvl) rdLvl = 1'($urandom_range(0, 1));
      else if (lowRun >= 2) rdLvl = ($urandom_range(0, 2) == 0);
      lowRun = rdLvl ? 0 : lowRun + 1;
      cycle("rand", rx, 8'($urandom), ($urandom_range(0, 7) == 0), rdLvl);
    end

    // Asynchronous reset with five entries stored.
    resetDut(1'b0);
    for (int i = 0; i < 6; i++) cycle("pre", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    readOne("preRead");
    chk("preResetCount", 32'(Count), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("asyncReset", 0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Rd_req held high through reset release yields one request.
    Rd_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    cycle("postRst", 1'b1, 8'h77, 1'b0, 1'b1);
    cycle("postRst", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("postRstPop", 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) cycle("postRstIdle", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
